// File: rtl/filter_preload_writer.sv
// Streaming weight loader for the three-PE filter buffer.
// It takes weights one per beat in filter -> channel -> kernel-row -> kernel-column
// order. It packs each kernel row into a single three-lane preload write, where
// kernel column k goes to PE k and the write address is the running row index.
// The design assumes KERNEL_SIZE == 3, one kernel column per PE.
module filter_preload_writer #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_FILTERS  = 1,
    parameter int NUM_CHANNELS = 1,
    parameter int KERNEL_SIZE  = 3,
    localparam int NUM_ROWS    = NUM_FILTERS * NUM_CHANNELS * KERNEL_SIZE,
    localparam int ADDR_WIDTH  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  preload_en,
    output logic [ADDR_WIDTH-1:0] preload_addr_pe0,
    output logic [ADDR_WIDTH-1:0] preload_addr_pe1,
    output logic [ADDR_WIDTH-1:0] preload_addr_pe2,
    output logic [DATA_WIDTH-1:0] preload_data_pe0,
    output logic [DATA_WIDTH-1:0] preload_data_pe1,
    output logic [DATA_WIDTH-1:0] preload_data_pe2,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NUM_ROWS - 1);

    state_t                state_q, state_d;
    logic [1:0]            col_q, col_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic [DATA_WIDTH-1:0] lane0_q, lane0_d;
    logic [DATA_WIDTH-1:0] lane1_q, lane1_d;
    logic                  pen_q, pen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data0_q, data0_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
    logic [DATA_WIDTH-1:0] data2_q, data2_d;
    logic                  accept;

    // Handshake and status come straight from the state. They therefore drop
    // together with an asynchronous reset.
    assign in_ready = (state_q == S_LOAD);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign accept   = in_valid && in_ready;

    // The three PEs always share one row address.
    assign preload_en       = pen_q;
    assign preload_addr_pe0 = addr_q;
    assign preload_addr_pe1 = addr_q;
    assign preload_addr_pe2 = addr_q;
    assign preload_data_pe0 = data0_q;
    assign preload_data_pe1 = data1_q;
    assign preload_data_pe2 = data2_q;

    // Next-state logic for the FSM, the column/row counters, the lane collection and the write register.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        lane0_d = lane0_q;
        lane1_d = lane1_q;
        pen_d   = 1'b0;
        addr_d  = addr_q;
        data0_d = data0_q;
        data1_d = data1_q;
        data2_d = data2_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    col_d   = '0;
                    row_d   = '0;
                    lane0_d = '0;
                    lane1_d = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (col_q == 2'd2) begin
                        // The third column completes the row. The last weight
                        // goes straight to PE2 and is not held in a lane.
                        pen_d   = 1'b1;
                        addr_d  = row_q;
                        data0_d = lane0_q;
                        data1_d = lane1_q;
                        data2_d = in_data;
                        col_d   = '0;
                        if (row_q == LAST_ROW) begin
                            state_d = S_DONE;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        if (col_q == 2'd0) begin
                            lane0_d = in_data;
                        end else begin
                            lane1_d = in_data;
                        end
                        col_d = col_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register. Reset returns to IDLE immediately and drops any partial row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            lane0_q <= '0;
            lane1_q <= '0;
            pen_q   <= 1'b0;
            addr_q  <= '0;
            data0_q <= '0;
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            lane0_q <= lane0_d;
            lane1_q <= lane1_d;
            pen_q   <= pen_d;
            addr_q  <= addr_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
        end
    end

endmodule

// File: tb/tb_filter_preload_writer.sv
// Bench for filter_preload_writer. Instance A uses the default 1x1 filter
// geometry and instance B uses a 2x2 geometry. Expected writes go into a
// per-instance queue when stimulus is driven. A monitor pops and compares them
// whenever preload_en fires.
module tb_filter_preload_writer;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] d2;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic        in_valid;
    logic [15:0] in_data;

    logic        rdy_a, pen_a, busy_a, done_a;
    logic [1:0]  a0_a, a1_a, a2_a;
    logic [15:0] d0_a, d1_a, d2_a;
    logic        rdy_b, pen_b, busy_b, done_b;
    logic [3:0]  a0_b, a1_b, a2_b;
    logic [15:0] d0_b, d1_b, d2_b;

    int errors = 0;
    int checks = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int pen_cnt_a = 0;
    wr_t q_a[$];
    wr_t q_b[$];
    wr_t tbl[3];

    always #5 clk = ~clk;

    filter_preload_writer dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_a), .preload_en(pen_a),
        .preload_addr_pe0(a0_a), .preload_addr_pe1(a1_a), .preload_addr_pe2(a2_a),
        .preload_data_pe0(d0_a), .preload_data_pe1(d1_a), .preload_data_pe2(d2_a),
        .busy(busy_a), .done(done_a)
    );

    filter_preload_writer #(.NUM_FILTERS(2), .NUM_CHANNELS(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_b), .preload_en(pen_b),
        .preload_addr_pe0(a0_b), .preload_addr_pe1(a1_b), .preload_addr_pe2(a2_b),
        .preload_data_pe0(d0_b), .preload_data_pe1(d1_b), .preload_data_pe2(d2_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard for instance A.
    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (pen_a) begin
            wr_t e;
            pen_cnt_a++;
            chk("a_write_was_expected", 64'(q_a.size() != 0), 64'd1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                chk("a_addr", {a0_a, a1_a, a2_a}, {e.addr[1:0], e.addr[1:0], e.addr[1:0]});
                chk("a_data", {d0_a, d1_a, d2_a}, {e.d0, e.d1, e.d2});
                $display("A write addr=%0d data=(%0d,%0d,%0d)", a0_a, d0_a, d1_a, d2_a);
            end
        end
    end

    // Scoreboard for instance B.
    always @(negedge clk) begin
        if (done_b) done_cnt_b++;
        if (pen_b) begin
            wr_t e;
            chk("b_write_was_expected", 64'(q_b.size() != 0), 64'd1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                chk("b_addr", {a0_b, a1_b, a2_b}, {e.addr, e.addr, e.addr});
                chk("b_data", {d0_b, d1_b, d2_b}, {e.d0, e.d1, e.d2});
                $display("B write addr=%0d data=(%0d,%0d,%0d)", a0_b, d0_b, d1_b, d2_b);
            end
        end
    end

    // Drive one beat after an optional idle gap. Called and returns at posedge+1.
    task automatic beat(input bit sel, input logic [15:0] v, input int gap);
        in_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = v;
        chk(sel ? "b_in_ready" : "a_in_ready", 64'(sel ? rdy_b : rdy_a), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Load instance sel with rows whose weights are base+3n, base+3n+1 and base+3n+2.
    task automatic load_rows(input bit sel, input int nrows, input int base, input int maxgap);
        for (int n = 0; n < nrows; n++) begin
            wr_t e;
            e.addr = 4'(n);
            e.d0 = 16'(base + 3 * n);
            e.d1 = 16'(base + 3 * n + 1);
            e.d2 = 16'(base + 3 * n + 2);
            if (sel) q_b.push_back(e);
            else     q_a.push_back(e);
            beat(sel, e.d0, (maxgap == 0) ? 0 : int'($urandom_range(maxgap)));
            beat(sel, e.d1, (maxgap == 0) ? 0 : int'($urandom_range(maxgap)));
            beat(sel, e.d2, (maxgap == 0) ? 0 : int'($urandom_range(maxgap)));
        end
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0; in_data = '0;
        #3;
        chk("reset_outputs_a", {rdy_a, pen_a, a0_a, a1_a, a2_a, d0_a, d1_a, d2_a, busy_a, done_a}, 64'd0);
        chk("reset_outputs_b", {rdy_b, pen_b, busy_b, done_b, d0_b}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Default geometry: nine back-to-back beats from a table.
        tbl[0] = '{addr: 4'd0, d0: 16'd1, d1: 16'd2, d2: 16'd3};
        tbl[1] = '{addr: 4'd1, d0: 16'd4, d1: 16'd5, d2: 16'd6};
        tbl[2] = '{addr: 4'd2, d0: 16'd7, d1: 16'd8, d2: 16'd9};
        pulse_start(1'b0);
        chk("a_busy_after_start", 64'(busy_a), 64'd1);
        for (int i = 0; i < 3; i++) begin
            q_a.push_back(tbl[i]);
            beat(1'b0, tbl[i].d0, 0);
            beat(1'b0, tbl[i].d1, 0);
            beat(1'b0, tbl[i].d2, 0);
        end
        @(negedge clk);
        chk("a_done_with_last_write", 64'({done_a, pen_a, busy_a, rdy_a}), 64'b1110);
        @(negedge clk);
        chk("a_done_one_cycle", 64'(done_a), 64'd0);
        chk("a_busy_falls", 64'(busy_a), 64'd0);
        chk("a_writes_drained", 64'(q_a.size()), 64'd0);
        chk("a_done_count_1", 64'(done_cnt_a), 64'd1);
        chk("a_data_held", {d0_a, d1_a, d2_a, 6'(a0_a)}, {16'd7, 16'd8, 16'd9, 6'd2});
        @(posedge clk); #1;

        // 2x2 geometry without gaps, then with random gaps.
        pulse_start(1'b1);
        load_rows(1'b1, 12, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("b_writes_drained", 64'(q_b.size()), 64'd0);
        chk("b_done_count_1", 64'(done_cnt_b), 64'd1);
        chk("b_idle_after_done", 64'(busy_b), 64'd0);
        pulse_start(1'b1);
        load_rows(1'b1, 12, 0, 5);
        repeat (3) @(posedge clk);
        #1;
        chk("b_gap_writes_drained", 64'(q_b.size()), 64'd0);
        chk("b_done_count_2", 64'(done_cnt_b), 64'd2);

        // A start pulse during beat 4 is ignored.
        pulse_start(1'b0);
        load_rows(1'b0, 1, 21, 0);
        start_a = 1'b1;
        q_a.push_back('{addr: 4'd1, d0: 16'd24, d1: 16'd25, d2: 16'd26});
        beat(1'b0, 16'd24, 0);
        start_a = 1'b0;
        beat(1'b0, 16'd25, 0);
        beat(1'b0, 16'd26, 0);
        q_a.push_back('{addr: 4'd2, d0: 16'd27, d1: 16'd28, d2: 16'd29});
        beat(1'b0, 16'd27, 0);
        beat(1'b0, 16'd28, 0);
        beat(1'b0, 16'd29, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("a_start_ignored_drained", 64'(q_a.size()), 64'd0);
        chk("a_done_count_2", 64'(done_cnt_a), 64'd2);

        // Reset after beat 5, then reload with 10..18.
        pulse_start(1'b0);
        load_rows(1'b0, 1, 1, 0);
        beat(1'b0, 16'd4, 0);
        beat(1'b0, 16'd5, 0);
        rst = 1'b1;
        #1;
        chk("a_async_reset_outputs", {rdy_a, pen_a, a0_a, a1_a, a2_a, d0_a, d1_a, d2_a, busy_a, done_a}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("a_no_done_after_abort", 64'(done_cnt_a), 64'd2);
        pulse_start(1'b0);
        load_rows(1'b0, 3, 10, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("a_reload_drained", 64'(q_a.size()), 64'd0);
        chk("a_done_count_3", 64'(done_cnt_a), 64'd3);

        // in_valid held high while idle and with no start: nothing happens.
        begin
            int pens_before;
            pens_before = pen_cnt_a;
            in_valid = 1'b1;
            in_data  = 16'd99;
            repeat (4) begin
                @(posedge clk); #1;
                chk("a_idle_not_ready", 64'({rdy_a, busy_a}), 64'd0);
            end
            in_valid = 1'b0;
            @(posedge clk); #1;
            chk("a_idle_no_writes", 64'(pen_cnt_a), 64'(pens_before));
        end

        chk("final_queue_a_empty", 64'(q_a.size()), 64'd0);
        chk("final_queue_b_empty", 64'(q_b.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
